bp_cce_lite_responder: RTL and testbench
========================================

BP_CCE_LITE_RESPONDER -- requirements
Module: bp_cce_lite_responder

Interface
REQ-001 Parameters SHALL be as follows.
- paddr_width_p, 40: physical address width.
- lce_id_width_p, 2: LCE id width.
- assoc_p, 8: ways; way field width wy = log2(assoc_p).
- block_width_p, 512: cache block width in bits.
- timeout_p, 255: maximum cycles in WAIT_ACK.

REQ-002 Ports SHALL be as follows.
- clk_i  in  1  sole clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- lce_req_i  in  2+lce_id+wy+paddr+64  {type, lce_id, way, addr, data} MSB-first; type 0 = cached read, 1 = uncached read, 2 = uncached write.
- lce_req_v_i  in  1  request valid.
- lce_req_ready_and_o  out  1  request ready.
- lce_cmd_o  out  3+lce_id+wy+paddr+block  {type, lce_id, way, addr, data}; type 0 = data fill, 1 = uc_data, 2 = uc_done.
- lce_cmd_v_o  out  1  command valid.
- lce_cmd_ready_and_i  in  1  command ready.
- lce_resp_i  in  2+lce_id+paddr  {type, lce_id, addr}; type 0 = coh_ack.
- lce_resp_v_i  in  1  response valid.
- lce_resp_ready_and_o  out  1  response ready.
- mem_cmd_o  out  2+paddr+64  {op, addr, data}; op 0 = block read, 1 = uc read, 2 = uc write.
- mem_cmd_v_o  out  1  memory command valid.
- mem_cmd_ready_and_i  in  1  memory command ready.
- mem_resp_i  in  block  memory read data.
- mem_resp_v_i  in  1  memory response valid.
- mem_resp_ready_and_o  out  1  memory response ready.
- error_o  out  1  sticky protocol error.
- txn_count_o  out  16  completed transactions.

Function
REQ-003 All handshakes SHALL be ready&valid: a transfer occurs in any cycle where both are 1; valid, once raised, SHALL hold with stable payload until the transfer.
REQ-004 The FSM SHALL have states READY, MEM_CMD, MEM_RESP, LCE_CMD, WAIT_ACK, and process exactly one transaction at a time.
REQ-005 READY: lce_req_ready_and_o=1, all other ready/valid outputs 0; on transfer, capture type, lce_id, way, addr and data, then go to MEM_CMD.
REQ-006 MEM_CMD: mem_cmd_v_o=1; op equals the captured type.
- Cached read: addr with its low log2(block_width_p/8) bits zeroed.
- Uncached read/write: addr unchanged.
- data = captured data for uncached write, else 0.
On transfer, go to MEM_RESP.
REQ-007 MEM_RESP: mem_resp_ready_and_o=1; on transfer, capture mem_resp_i, then go to LCE_CMD.
REQ-008 Uncached write SHALL still wait for one mem_resp beat (write ack); its data is ignored.
REQ-009 LCE_CMD: lce_cmd_v_o=1; lce_id, way and addr echo the captured request (addr unaligned). Command type and data:
- Cached read: type 0, full block.
- Uncached read: type 1, data = mem_resp[63:0] zero-extended.
- Uncached write: type 2, data 0.
REQ-010 On an LCE_CMD transfer: cached read goes to WAIT_ACK; otherwise go to READY and increment txn_count_o.
REQ-011 WAIT_ACK: lce_resp_ready_and_o=1 and the timeout counter increments each cycle.
- Response with type 0 and lce_id matching the captured id: increment txn_count_o, clear the counter, go to READY.
- Any other response: consume it, set error_o, remain in WAIT_ACK.
REQ-012 Timeout: when the counter reaches timeout_p with no ack, set error_o and go to READY without incrementing txn_count_o.
REQ-013 lce_resp_ready_and_o SHALL be 0 outside WAIT_ACK; responses arriving then SHALL stay pending.
REQ-014 txn_count_o SHALL wrap from 0xFFFF to 0; error_o SHALL clear only on reset.
REQ-015 A new request SHALL never be accepted in the same cycle the previous transaction completes; READY is entered first.

Reset
REQ-016 While reset_n_i=0, asynchronously: state=READY, all captured registers 0, timeout counter 0, txn_count_o=0, error_o=0, every valid and ready output 0 except lce_req_ready_and_o=1.
REQ-017 Reset asserted mid-transaction SHALL abort it with no further output; after deassertion the first accepted request starts clean.

Verification
REQ-018 Cached read addr 0x80001234, lce_id 1, way 3, memory returns block B, ack with lce_id 1 -> mem_cmd op 0 addr 0x80001200; lce_cmd type 0, addr 0x80001234, data B; txn_count 1; error 0.
REQ-019 Uncached read 0x80000008, mem_resp low dword 0xDEADBEEF -> lce_cmd type 1, data 0xDEADBEEF zero-extended; no WAIT_ACK; txn_count +1.
REQ-020 Uncached write 0x10, data 0x55 with mem_cmd_ready_and_i stalled 5 cycles -> mem_cmd payload stable for all 5 cycles; lce_cmd type 2 follows the mem_resp beat.
REQ-021 Cached read answered with ack lce_id 2 (captured id 1), then ack lce_id 1 -> error_o=1, both responses consumed, returns to READY, txn_count +1.
REQ-022 Cached read never acked -> READY after timeout_p cycles in WAIT_ACK, error_o=1, txn_count unchanged; reset_n_i pulsed in MEM_RESP -> all outputs at their reset values immediately.

Source files
------------

// File: rtl/bp_cce_lite_responder_if.sv
// bp_cce_lite_responder_if: LCE request/command/response and memory channels of the lite CCE responder
interface bp_cce_lite_responder_if #(
    parameter int paddr_width_p  = 40,
    parameter int lce_id_width_p = 2,
    parameter int assoc_p        = 8,
    parameter int block_width_p  = 512
);
    localparam int wy     = $clog2(assoc_p);
    localparam int req_w  = 2 + lce_id_width_p + wy + paddr_width_p + 64;
    localparam int cmd_w  = 3 + lce_id_width_p + wy + paddr_width_p + block_width_p;
    localparam int resp_w = 2 + lce_id_width_p + paddr_width_p;
    localparam int mem_w  = 2 + paddr_width_p + 64;
    logic [req_w-1:0]         lce_req_i;
    logic                     lce_req_v_i;
    logic                     lce_req_ready_and_o;
    logic [cmd_w-1:0]         lce_cmd_o;
    logic                     lce_cmd_v_o;
    logic                     lce_cmd_ready_and_i;
    logic [resp_w-1:0]        lce_resp_i;
    logic                     lce_resp_v_i;
    logic                     lce_resp_ready_and_o;
    logic [mem_w-1:0]         mem_cmd_o;
    logic                     mem_cmd_v_o;
    logic                     mem_cmd_ready_and_i;
    logic [block_width_p-1:0] mem_resp_i;
    logic                     mem_resp_v_i;
    logic                     mem_resp_ready_and_o;
    logic                     error_o;
    logic [15:0]              txn_count_o;
    modport slave (
        input  lce_req_i, lce_req_v_i, lce_cmd_ready_and_i, lce_resp_i, lce_resp_v_i,
        input  mem_cmd_ready_and_i, mem_resp_i, mem_resp_v_i,
        output lce_req_ready_and_o, lce_cmd_o, lce_cmd_v_o, lce_resp_ready_and_o,
        output mem_cmd_o, mem_cmd_v_o, mem_resp_ready_and_o, error_o, txn_count_o
    );
    modport master (
        output lce_req_i, lce_req_v_i, lce_cmd_ready_and_i, lce_resp_i, lce_resp_v_i,
        output mem_cmd_ready_and_i, mem_resp_i, mem_resp_v_i,
        input  lce_req_ready_and_o, lce_cmd_o, lce_cmd_v_o, lce_resp_ready_and_o,
        input  mem_cmd_o, mem_cmd_v_o, mem_resp_ready_and_o, error_o, txn_count_o
    );
endinterface

// File: rtl/bp_cce_lite_responder.sv
// bp_cce_lite_responder: single-transaction CCE serving cached/uncached LCE requests from memory
module bp_cce_lite_responder #(
    parameter int paddr_width_p  = 40,
    parameter int lce_id_width_p = 2,
    parameter int assoc_p        = 8,
    parameter int block_width_p  = 512,
    parameter int timeout_p      = 255
) (
    input logic                    clk_i,
    input logic                    reset_n_i,
    bp_cce_lite_responder_if.slave bus
);
    localparam int wy = $clog2(assoc_p);
    localparam int cw = $clog2(timeout_p + 1);
    typedef enum logic [2:0] {READY, MEM_CMD, MEM_RESP, LCE_CMD, WAIT_ACK} state_e;
    state_e state, state_n;
    logic [1:0]                r_type;
    logic [lce_id_width_p-1:0] r_id;
    logic [wy-1:0]             r_way;
    logic [paddr_width_p-1:0]  r_addr;
    logic [63:0]               r_data;
    logic [block_width_p-1:0]  r_blk;
    logic [block_width_p-1:0]  cmd_data;
    logic [paddr_width_p-1:0]  mem_addr;
    logic [cw-1:0]             cnt;
    logic [15:0]               txn;
    logic                      err, cached, ack, bad, done, timeout;
    assign cached   = r_type == 2'd0;
    assign mem_addr = cached ? r_addr & ~paddr_width_p'(block_width_p / 8 - 1) : r_addr;
    assign cmd_data = cached ? r_blk : r_type == 2'd1 ? block_width_p'(r_blk[63:0]) : '0;
    assign bus.mem_cmd_o   = {r_type, mem_addr, r_type == 2'd2 ? r_data : 64'h0};
    assign bus.lce_cmd_o   = {1'b0, r_type, r_id, r_way, r_addr, cmd_data};
    assign bus.error_o     = err;
    assign bus.txn_count_o = txn;
    always_comb begin
        state_n = state;
        ack = 1'b0;
        bad = 1'b0;
        done = 1'b0;
        timeout = 1'b0;
        bus.lce_req_ready_and_o  = state == READY;
        bus.mem_cmd_v_o          = state == MEM_CMD;
        bus.mem_resp_ready_and_o = state == MEM_RESP;
        bus.lce_cmd_v_o          = state == LCE_CMD;
        bus.lce_resp_ready_and_o = state == WAIT_ACK;
        case (state)
            READY:    state_n = bus.lce_req_v_i ? MEM_CMD : READY;
            MEM_CMD:  state_n = bus.mem_cmd_ready_and_i ? MEM_RESP : MEM_CMD;
            MEM_RESP: state_n = bus.mem_resp_v_i ? LCE_CMD : MEM_RESP;
            LCE_CMD: begin
                done = bus.lce_cmd_ready_and_i && !cached;
                state_n = !bus.lce_cmd_ready_and_i ? LCE_CMD : cached ? WAIT_ACK : READY;
            end
            WAIT_ACK: begin
                ack = bus.lce_resp_v_i && bus.lce_resp_i[lce_id_width_p+paddr_width_p +: 2] == 2'd0
                      && bus.lce_resp_i[paddr_width_p +: lce_id_width_p] == r_id;
                bad = bus.lce_resp_v_i && !ack;
                timeout = !ack && cnt == cw'(timeout_p - 1);
                done = ack;
                state_n = (ack || timeout) ? READY : WAIT_ACK;
            end
            default: state_n = READY;
        endcase
    end
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) state <= READY;
        else state <= state_n;
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            {r_type, r_id, r_way, r_addr, r_data} <= '0;
            r_blk <= '0;
            cnt <= '0;
            txn <= '0;
            err <= 1'b0;
        end else begin
            if (state == READY && bus.lce_req_v_i) {r_type, r_id, r_way, r_addr, r_data} <= bus.lce_req_i;
            if (state == MEM_RESP && bus.mem_resp_v_i) r_blk <= bus.mem_resp_i;
            cnt <= (state == WAIT_ACK && !ack && !timeout) ? cnt + 1'b1 : '0;
            if (done) txn <= txn + 1'b1;
            if (bad || timeout) err <= 1'b1;
        end
endmodule

// File: tb/tb_bp_cce_lite_responder.sv
// tb_bp_cce_lite_responder: directed and randomized transactions checked against a spec-level model
module tb_bp_cce_lite_responder;
    localparam int tp = 255;
    logic clk_i = 1'b0;
    logic reset_n_i = 1'b0;
    int checks = 0;
    int fails = 0;
    int exp_txn = 0;
    logic exp_err = 1'b0;
    bp_cce_lite_responder_if bus ();
    bp_cce_lite_responder dut (.clk_i(clk_i), .reset_n_i(reset_n_i), .bus(bus));
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    function automatic logic [511:0] rnd_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, bus.lce_req_ready_and_o, 1);
        chk({tag, "_mem_cmd_v"}, bus.mem_cmd_v_o, 0);
        chk({tag, "_mem_resp_ready"}, bus.mem_resp_ready_and_o, 0);
        chk({tag, "_lce_cmd_v"}, bus.lce_cmd_v_o, 0);
        chk({tag, "_resp_ready"}, bus.lce_resp_ready_and_o, 0);
        chk({tag, "_txn"}, bus.txn_count_o, 16'(exp_txn));
        chk({tag, "_err"}, bus.error_o, exp_err);
    endtask

    // mode: 0 = correct ack, 1 = wrong-id response then correct ack, 2 = never acked
    task automatic txn(input logic [1:0] t, input logic [1:0] id, input logic [2:0] way,
                       input logic [39:0] addr, input logic [63:0] data, input logic [511:0] blk,
                       input int stall, input int mode);
        logic [105:0] emem;
        logic [559:0] ecmd;
        int n;
        emem = {t, t == 2'd0 ? addr & ~40'h3f : addr, t == 2'd2 ? data : 64'h0};
        ecmd = {1'b0, t, id, way, addr, t == 2'd0 ? blk : t == 2'd1 ? {448'h0, blk[63:0]} : 512'h0};
        chk("req_ready", bus.lce_req_ready_and_o, 1);
        if (t != 2'd0) begin
            bus.lce_resp_i = {2'd0, id, addr};
            bus.lce_resp_v_i = 1'b1;
        end
        bus.lce_req_i = {t, id, way, addr, data};
        bus.lce_req_v_i = 1'b1;
        step();
        bus.lce_req_v_i = 1'b0;
        bus.lce_req_i = '1;
        for (int i = 0; i <= stall; i++) begin
            chk("mem_cmd_v", bus.mem_cmd_v_o, 1);
            chk("mem_cmd", bus.mem_cmd_o, emem);
            chk("req_ready_busy", bus.lce_req_ready_and_o, 0);
            chk("resp_ready_busy", bus.lce_resp_ready_and_o, 0);
            if (i == stall) bus.mem_cmd_ready_and_i = 1'b1;
            step();
        end
        bus.mem_cmd_ready_and_i = 1'b0;
        chk("mem_resp_ready", bus.mem_resp_ready_and_o, 1);
        chk("mem_cmd_v_off", bus.mem_cmd_v_o, 0);
        bus.mem_resp_i = blk;
        bus.mem_resp_v_i = 1'b1;
        step();
        bus.mem_resp_v_i = 1'b0;
        bus.mem_resp_i = '1;
        chk("lce_cmd_v", bus.lce_cmd_v_o, 1);
        chk("lce_cmd", bus.lce_cmd_o, ecmd);
        chk("req_ready_cmd", bus.lce_req_ready_and_o, 0);
        bus.lce_cmd_ready_and_i = 1'b1;
        step();
        bus.lce_cmd_ready_and_i = 1'b0;
        if (t == 2'd0) begin
            chk("resp_ready", bus.lce_resp_ready_and_o, 1);
            if (mode == 2) begin
                n = 0;
                while (bus.lce_resp_ready_and_o && n < tp + 20) begin
                    n++;
                    @(negedge clk_i);
                end
                chk("wait_ack_cycles", n, tp);
                exp_err = 1'b1;
            end else begin
                if (mode == 1) begin
                    bus.lce_resp_i = {2'd0, id + 2'd1, addr};
                    bus.lce_resp_v_i = 1'b1;
                    step();
                    chk("still_waiting", bus.lce_resp_ready_and_o, 1);
                    chk("err_after_bad", bus.error_o, 1);
                    exp_err = 1'b1;
                end
                bus.lce_resp_i = {2'd0, id, addr};
                bus.lce_resp_v_i = 1'b1;
                step();
                bus.lce_resp_v_i = 1'b0;
                exp_txn++;
            end
        end else begin
            bus.lce_resp_v_i = 1'b0;
            exp_txn++;
        end
        chk_idle_outputs("done");
    endtask

    initial begin
        logic [1:0] t;
        bus.lce_req_i = '0;
        bus.lce_req_v_i = 1'b0;
        bus.lce_cmd_ready_and_i = 1'b0;
        bus.lce_resp_i = '0;
        bus.lce_resp_v_i = 1'b0;
        bus.mem_cmd_ready_and_i = 1'b0;
        bus.mem_resp_i = '0;
        bus.mem_resp_v_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_idle_outputs("reset");
        reset_n_i = 1'b1;
        @(negedge clk_i);
        txn(2'd0, 2'd1, 3'd3, 40'h80001234, 64'h0, rnd_blk(), 0, 0);
        chk("cached_read_no_err", bus.error_o, 0);
        txn(2'd1, 2'd2, 3'd5, 40'h80000008, 64'h1234, {rnd_blk() >> 64, 64'hDEADBEEF}, 1, 0);
        txn(2'd2, 2'd0, 3'd1, 40'h10, 64'h55, rnd_blk(), 5, 0);
        txn(2'd0, 2'd1, 3'd6, 40'h80002040, 64'h0, rnd_blk(), 0, 1);
        for (int k = 0; k < 10; k++) begin
            t = 2'($urandom_range(0, 2));
            txn(t, 2'($urandom), 3'($urandom), {8'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
                rnd_blk(), $urandom_range(0, 3), t == 2'd0 ? $urandom_range(0, 1) : 0);
        end
        txn(2'd0, 2'd3, 3'd2, 40'h40, 64'h0, rnd_blk(), 2, 2);
        bus.lce_req_i = {2'd0, 2'd1, 3'd0, 40'h80001000, 64'h0};
        bus.lce_req_v_i = 1'b1;
        step();
        bus.lce_req_v_i = 1'b0;
        bus.mem_cmd_ready_and_i = 1'b1;
        step();
        bus.mem_cmd_ready_and_i = 1'b0;
        chk("pre_reset_mem_resp_ready", bus.mem_resp_ready_and_o, 1);
        reset_n_i = 1'b0;
        #1;
        exp_txn = 0;
        exp_err = 1'b0;
        chk_idle_outputs("async_reset");
        @(negedge clk_i);
        reset_n_i = 1'b1;
        bus.lce_cmd_ready_and_i = 1'b1;
        step();
        chk("post_reset_no_cmd", bus.lce_cmd_v_o, 0);
        bus.lce_cmd_ready_and_i = 1'b0;
        txn(2'd1, 2'd2, 3'd4, 40'h80000100, 64'h0, rnd_blk(), 0, 0);
        txn(2'd0, 2'd0, 3'd7, 40'h123456789a, 64'h0, rnd_blk(), 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
